// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone memory slave.
// Field widths are sized for the largest supported configuration
// (32-bit data, up to 65536 memory words). Smaller instances leave the
// upper index bits at zero.
package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
  localparam int WB_IDX_WIDTH  = 16;

  // One queued bus request, captured at acceptance time.
  typedef struct packed {
    logic                     we;
    logic [WB_IDX_WIDTH-1:0]  idx;
    logic [WB_DATA_WIDTH-1:0] dat;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic                     ok;   // word index lies inside the memory
  } wb_req_t;

  // Request server states.
  typedef enum logic [0:0] {
    SRV_IDLE = 1'b0,
    SRV_BUSY = 1'b1
  } wb_srv_state_e;

endpackage

// File: rtl/wb_req_fifo.sv
// In-order request queue for the Wishbone memory slave.
// Push and pop in the same cycle are both honored. Flush empties the queue
// at the next edge. Push while full and pop while empty are ignored.
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  wb_req_t                push_data_i,
  input  logic                   pop_i,
  output wb_req_t                pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy tracking; flush behaves like a reset of the queue.
  // NOTE: state is updated with <= so every register samples the pre-edge
  // values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; validity is carried by the
  // pointers and count alone, which keeps the storage a plain register file.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave backed by an on-chip word memory.
// Accepted requests are queued in order and served one at a time, each
// taking LATENCY cycles. The response (ack or err, plus read data) is
// registered in the cycle the request executes. Dropping wb_cyc_i aborts
// everything queued or in flight.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic                    wb_stall_o
);

  localparam int         IDX_W      = $clog2(MEM_WORDS);
  localparam int         SEL_W      = DATA_WIDTH / 8;
  localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAT_RELOAD = 4'(LATENCY - 1);

  localparam logic [0:0] ST_IDLE = SRV_IDLE;
  localparam logic [0:0] ST_BUSY = SRV_BUSY;

  // Request queue interface
  wb_req_t          push_req;
  wb_req_t          head_req;
  logic             accept;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Server state
  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  wb_req_t          cur_q, cur_d;
  logic             exec;
  logic [IDX_W-1:0] cur_idx;

  // Response registers
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dat_q;

  // Word memory
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Address byte offset and idle index/count bits carry no function here.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], cur_q.idx, fifo_count};

  // Stall comes straight from the registered queue occupancy, so it has no
  // combinational dependence on the bus inputs.
  assign wb_stall_o = fifo_full;
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;
  assign cur_idx    = cur_q.idx[IDX_W-1:0];

  // Capture the bus request into queue format, including the range check.
  always_comb begin
    push_req                     = '0;
    push_req.we                  = wb_we_i;
    push_req.idx[IDX_W-1:0]      = wb_adr_i[2 +: IDX_W];
    push_req.dat[DATA_WIDTH-1:0] = wb_dat_i;
    push_req.sel[SEL_W-1:0]      = wb_sel_i;
    // MEM_WORDS is a power of two, so "word address < MEM_WORDS" reduces to
    // all address bits above the index being zero.
    push_req.ok                  = (wb_adr_i[ADDR_WIDTH-1:2+IDX_W] == '0);
  end

  wb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .flush_i     (!wb_cyc_i),
    .push_i      (accept),
    .push_data_i (push_req),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Server next-state: pop, count down the access latency, then execute.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    exec     = 1'b0;
    if (wb_rst_i || !wb_cyc_i) begin
      // Abort: the in-flight request is dropped without executing.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = head_req;
            cnt_d    = LAT_RELOAD;
            state_d  = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            exec = 1'b1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              cur_d    = head_req;
              cnt_d    = LAT_RELOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Server state registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // Byte-lane memory write for an in-range executing write.
  always_ff @(posedge wb_clk_i) begin
    if (exec && cur_q.ok && cur_q.we) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (cur_q.sel[i]) mem[cur_idx][8*i +: 8] <= cur_q.dat[8*i +: 8];
      end
    end
  end

  // Register the completion: ack for in-range requests, err otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= exec && cur_q.ok;
      err_q <= exec && !cur_q.ok;
      if (exec) dat_q <= (cur_q.ok && !cur_q.we) ? mem[cur_idx] : '0;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed testbench for wb_mem_slave (LATENCY=2, FIFO_DEPTH=4, MEM_WORDS=1024).
// A cycle counter numbers clock cycles; a monitor logs every completion
// with its cycle so latency, ordering and data can be compared with
// hand-computed values.
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack, err, rty, stall;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] dat;
  } comp_t;

  comp_t comp_q[$];
  int    both_hi = 0;
  int    no_cyc  = 0;
  logic  cyc_prev = 1'b0;

  wb_mem_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_WORDS  (1024),
    .LATENCY    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_sel_i   (sel),
    .wb_dat_o   (dat_r),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .wb_stall_o (stall)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval following the k-th rising edge.
  always @(posedge clk) begin
    cyc_cnt  <= cyc_cnt + 1;
    cyc_prev <= cyc;
  end

  // Completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ack === 1'b1 || err === 1'b1) comp_q.push_back('{cyc_cnt, err, dat_r});
    if (ack === 1'b1 && err === 1'b1) both_hi++;
    if ((ack === 1'b1 || err === 1'b1) && !cyc_prev) no_cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request in the next cycle and hold it until accepted.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc, output int stalls);
    acc    = -1;
    stalls = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (stall === 1'b0) begin
        acc = cyc_cnt;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(acc >= 0), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 200 && comp_q.size() < n; k++) begin
      @(posedge clk); #2;
    end
    check("done_timeout", 32'(comp_q.size() >= n), 32'd1);
  endtask

  task automatic take(output comp_t c);
    if (comp_q.size() > 0) begin
      c = comp_q.pop_front();
    end else begin
      c.cyc = -1; c.err = 1'bx; c.dat = 'x;
    end
  endtask

  initial begin
    comp_t c;
    int    a, b, st;
    int    acc [10];
    int    stl [10];
    int    exp_off [10] = '{0, 1, 2, 3, 4, 5, 6, 8, 10, 12};
    int    exp_stl [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rty", 32'(rty), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dat", dat_r, 32'h0);

    // Single write then single read into an idle slave: ack at A+4 / B+4.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a, st);
    idle();
    wait_done(1);
    take(c);
    check("t1_wr_cyc", 32'(c.cyc), 32'(a + 4));
    check("t1_wr_err", 32'(c.err), 32'd0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, b, st);
    idle();
    wait_done(1);
    take(c);
    check("t1_rd_cyc", 32'(c.cyc), 32'(b + 4));
    check("t1_rd_err", 32'(c.err), 32'd0);
    check("t1_rd_dat", c.dat, 32'hDEADBEEF);

    // Byte lanes: full write, lanes 0 and 2 overwritten, then read.
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, a, st);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, a, st);
    issue(1'b0, 32'h20, 32'h0, 4'hF, a, st);
    idle();
    wait_done(3);
    take(c); check("t2_wr0_err", 32'(c.err), 32'd0);
    take(c); check("t2_wr1_err", 32'(c.err), 32'd0);
    take(c); check("t2_rd_dat", c.dat, 32'h11BB33DD);

    // Backpressure: ten back-to-back reads. The queue gains one entry every
    // two cycles, reaches four on the 7th acceptance, and from then on
    // every further request waits one stalled cycle.
    for (int k = 0; k < 10; k++)
      issue(1'b0, (k % 2 == 1) ? 32'h20 : 32'h10, 32'h0, 4'hF, acc[k], stl[k]);
    idle();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t3_acc%0d", k), 32'(acc[k] - acc[0]), 32'(exp_off[k]));
      check($sformatf("t3_stall%0d", k), 32'(stl[k]), 32'(exp_stl[k]));
    end
    wait_done(10);
    for (int k = 0; k < 10; k++) begin
      take(c);
      check($sformatf("t3_ack_cyc%0d", k), 32'(c.cyc), 32'(acc[0] + 4 + 2 * k));
      check($sformatf("t3_dat%0d", k), c.dat, (k % 2 == 1) ? 32'h11BB33DD : 32'hDEADBEEF);
    end
    @(negedge clk);
    check("t3_stall_drained", 32'(stall), 32'd0);

    // Out of range: 0x1000 is word 1024; its low index bits alias word 0.
    issue(1'b1, 32'h0, 32'h0BADF00D, 4'hF, a, st);
    issue(1'b0, 32'h1000, 32'h0, 4'hF, a, st);
    issue(1'b1, 32'h1000, 32'h55555555, 4'hF, a, st);
    issue(1'b0, 32'h0, 32'h0, 4'hF, a, st);
    idle();
    wait_done(4);
    take(c); check("t4_wr0_err", 32'(c.err), 32'd0);
    take(c); check("t4_rd_oor_err", 32'(c.err), 32'd1);
    check("t4_rd_oor_dat", c.dat, 32'h0);
    take(c); check("t4_wr_oor_err", 32'(c.err), 32'd1);
    take(c); check("t4_rd0_err", 32'(c.err), 32'd0);
    check("t4_rd0_dat", c.dat, 32'h0BADF00D);

    // Abort: preset words 2 and 3, queue three writes, drop cyc in A+4.
    issue(1'b1, 32'h8, 32'h22222222, 4'hF, a, st);
    issue(1'b1, 32'hC, 32'h33333333, 4'hF, a, st);
    idle();
    wait_done(2);
    take(c); take(c);
    issue(1'b1, 32'h4, 32'h11111111, 4'hF, a, st);
    issue(1'b1, 32'h8, 32'hBAD22222, 4'hF, b, st);
    issue(1'b1, 32'hC, 32'hBAD33333, 4'hF, b, st);
    idle();                       // cycle A+3: first write executes
    @(posedge clk); #1 cyc = 1'b0; // cycle A+4: abort
    @(posedge clk); #1 cyc = 1'b1; // cycle A+5
    @(negedge clk);
    check("t5_stall_after", 32'(stall), 32'd0);
    check("t5_ack_after", 32'(ack), 32'd0);
    check("t5_err_after", 32'(err), 32'd0);
    repeat (10) @(posedge clk);
    #2 check("t5_completions", 32'(comp_q.size()), 32'd1);
    take(c);
    check("t5_ack_cyc", 32'(c.cyc), 32'(a + 4));
    issue(1'b0, 32'h4, 32'h0, 4'hF, a, st);
    issue(1'b0, 32'h8, 32'h0, 4'hF, a, st);
    issue(1'b0, 32'hC, 32'h0, 4'hF, a, st);
    idle();
    wait_done(3);
    take(c); check("t5_word1", c.dat, 32'h11111111);
    take(c); check("t5_word2", c.dat, 32'h22222222);
    take(c); check("t5_word3", c.dat, 32'h33333333);

    // Reset while three reads are pending.
    issue(1'b0, 32'h10, 32'h0, 4'hF, a, st);
    issue(1'b0, 32'h10, 32'h0, 4'hF, a, st);
    issue(1'b0, 32'h10, 32'h0, 4'hF, a, st);
    @(posedge clk); #1 stb = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_rty", 32'(rty), 32'd0);
    check("t6_stall", 32'(stall), 32'd0);
    check("t6_dat", dat_r, 32'h0);
    repeat (12) @(posedge clk);
    #2 check("t6_no_completion", 32'(comp_q.size()), 32'd0);

    // Protocol invariants over the whole run.
    check("ack_err_both_high", 32'(both_hi), 32'd0);
    check("completion_without_cyc", 32'(no_cyc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
